serial_add_seq: RTL

SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

---
 rtl/serial_add_seq.sv | 97 +++++++++
 1 files changed

// File: rtl/serial_add_seq.sv
// Bit-serial adder: a+b+cin over WIDTH clocks through one full-adder stage, LSB first.
// The results stay registered until the next completion.
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q, b_q, acc_q, sum_q;
    logic             carry_q, busy_q, done_q, cout_q, ovf_q;

    logic             s_bit, c_nxt, c_msb, last_bit;
    logic [WIDTH-1:0] acc_d;

    assign s_bit    = a_q[0] ^ b_q[0] ^ carry_q;
    assign c_nxt    = (a_q[0] & b_q[0]) | ((a_q[0] ^ b_q[0]) & carry_q);
    assign acc_d    = {s_bit, acc_q[WIDTH-1:1]};
    assign last_bit = (cnt_q == CW'(WIDTH - 1));
    // On the last RUN edge the carry flop holds the carry into the MSB.
    assign c_msb    = carry_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    acc_q   <= acc_d;
                    carry_q <= c_nxt;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last_bit) begin
                        sum_q   <= acc_d;
                        cout_q  <= c_nxt;
                        ovf_q   <= c_msb ^ c_nxt;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
endmodule
